t01_ram_responder: RTL and testbench

T01_RAM_RESPONDER -- requirements
Module: t01_ram_responder

---
 rtl/t01_ram_responder.sv | 110 +++++++++++
 tb/tb_t01_ram_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/t01_ram_responder.sv
// Wait-stated word RAM target for a read/write strobe initiator.
// Byte-lane writes, late address capture, out-of-range error pulse.
module t01_ram_responder #(
  parameter int unsigned WORDS       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] cpu_dat_i,
  input  logic [3:0]  sel_i,
  output logic        busy_o,
  output logic [31:0] cpu_dat_o,
  output logic        err_o
);

  localparam int AW = $clog2(WORDS);
  localparam logic [32:0] LIMIT = 33'(WORDS) << 2;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    WAIT,
    DONE
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic [3:0]  r_cnt;
  logic [31:0] r_mem [WORDS];

  logic [31:0]   w_off;
  logic          w_hit;
  logic [AW-1:0] w_idx;
  logic          w_wr;

  assign w_off = r_adr - BASE_ADDR;
  assign w_hit = {1'b0, w_off} < LIMIT;
  assign w_idx = w_off[AW+1:2];
  assign w_wr  = (r_state == DONE) && r_we && w_hit;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      busy_o    <= 1'b0;
      err_o     <= 1'b0;
      cpu_dat_o <= '0;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
    end else begin
      err_o <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (read_i || write_i) begin
            r_we    <= write_i;
            busy_o  <= 1'b1;
            r_state <= CAPTURE;
          end
        end
        // address may trail the strobe by one cycle
        CAPTURE: begin
          r_adr <= adr_i;
          r_dat <= cpu_dat_i;
          r_sel <= sel_i;
          if (WAIT_CYCLES == 0) begin
            r_state <= DONE;
          end else begin
            r_cnt   <= 4'(WAIT_CYCLES);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_cnt   <= '0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          busy_o  <= 1'b0;
          err_o   <= !w_hit;
          r_state <= IDLE;
          if (!r_we) begin
            cpu_dat_o <= w_hit ? r_mem[w_idx] : 32'hBAD0_BAD0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (r_sel[k]) r_mem[w_idx][8*k +: 8] <= r_dat[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_t01_ram_responder.sv
// Bench for t01_ram_responder: two instances (2 wait / 0 wait,
// offset base) against an array model of the addressed storage.
module tb_t01_ram_responder;

  logic        clk;
  logic        nRST;
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] adr  [2];
  logic [31:0] dati [2];
  logic [3:0]  sel  [2];
  logic        busy [2];
  logic [31:0] dato [2];
  logic        err  [2];

  int n_chk;
  int n_err;

  logic [31:0] m       [2][256];
  logic [31:0] last_rd [2];

  t01_ram_responder #(
    .WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)
  ) u_dut0 (
    .clk(clk), .nRST(nRST),
    .read_i(rd[0]), .write_i(wr[0]),
    .adr_i(adr[0]), .cpu_dat_i(dati[0]), .sel_i(sel[0]),
    .busy_o(busy[0]), .cpu_dat_o(dato[0]), .err_o(err[0])
  );

  t01_ram_responder #(
    .WORDS(16), .BASE_ADDR(32'h1000), .WAIT_CYCLES(0)
  ) u_dut1 (
    .clk(clk), .nRST(nRST),
    .read_i(rd[1]), .write_i(wr[1]),
    .adr_i(adr[1]), .cpu_dat_i(dati[1]), .sel_i(sel[1]),
    .busy_o(busy[1]), .cpu_dat_o(dato[1]), .err_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int words(input int d);
    return (d == 0) ? 256 : 16;
  endfunction

  function automatic logic [31:0] base(input int d);
    return (d == 0) ? 32'h0 : 32'h1000;
  endfunction

  function automatic bit in_rng(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = a - base(d);
    return off < 32'(4 * words(d));
  endfunction

  function automatic int widx(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = a - base(d);
    return int'(off >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input int d, input bit we, input logic [31:0] a,
                        input logic [31:0] dat, input logic [3:0] s,
                        input bit late, input bit both);
    int n;
    bit hit;
    int idx;
    @(negedge clk);
    rd[d]   = !we || both;
    wr[d]   = we;
    adr[d]  = late ? 32'h0 : a;
    dati[d] = late ? ~dat : dat;
    sel[d]  = late ? ~s : s;
    @(negedge clk);
    rd[d]   = 1'b0;
    wr[d]   = 1'b0;
    adr[d]  = a;
    dati[d] = dat;
    sel[d]  = s;
    n = 0;
    while (busy[d] && n < 40) begin
      n++;
      if (n >= 2) begin
        rd[d]   = 1'($urandom);
        wr[d]   = 1'($urandom);
        adr[d]  = $urandom;
        dati[d] = $urandom;
        sel[d]  = 4'($urandom);
      end
      @(negedge clk);
    end
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    chk("busy_len", 32'(n), 32'(2 + wc(d)));
    hit = in_rng(d, a);
    idx = widx(d, a);
    if (we && hit) begin
      for (int k = 0; k < 4; k++)
        if (s[k]) m[d][idx][8*k +: 8] = dat[8*k +: 8];
    end
    if (!we) last_rd[d] = hit ? m[d][idx] : 32'hBAD0_BAD0;
    chk("err", 32'(err[d]), 32'(!hit));
    chk("dato", dato[d], last_rd[d]);
    @(negedge clk);
    chk("err_pulse", 32'(err[d]), 32'h0);
    chk("idle", 32'(busy[d]), 32'h0);
  endtask

  task automatic back2back(input logic [31:0] a1, input logic [31:0] a2);
    @(negedge clk);
    rd[1]  = 1'b1;
    adr[1] = a1;
    @(negedge clk);
    chk("b2b_cap1", 32'(busy[1]), 32'h1);
    @(negedge clk);
    chk("b2b_done1", 32'(busy[1]), 32'h1);
    adr[1] = a2;
    @(negedge clk);
    chk("b2b_idle1", 32'(busy[1]), 32'h0);
    chk("b2b_dat1", dato[1], m[1][widx(1, a1)]);
    @(negedge clk);
    chk("b2b_cap2", 32'(busy[1]), 32'h1);
    @(negedge clk);
    chk("b2b_done2", 32'(busy[1]), 32'h1);
    rd[1] = 1'b0;
    @(negedge clk);
    chk("b2b_idle2", 32'(busy[1]), 32'h0);
    chk("b2b_dat2", dato[1], m[1][widx(1, a2)]);
    last_rd[1] = m[1][widx(1, a2)];
    @(negedge clk);
    chk("b2b_stop", 32'(busy[1]), 32'h0);
  endtask

  task automatic reset_mid(input logic [31:0] a);
    @(negedge clk);
    wr[0]   = 1'b1;
    adr[0]  = a;
    dati[0] = ~m[0][widx(0, a)];
    sel[0]  = 4'hF;
    @(negedge clk);
    wr[0] = 1'b0;
    @(negedge clk);
    chk("rst_pre_busy", 32'(busy[0]), 32'h1);
    nRST = 1'b0;
    #1;
    chk("rst_busy", 32'(busy[0]), 32'h0);
    chk("rst_dato", dato[0], 32'h0);
    chk("rst_err", 32'(err[0]), 32'h0);
    @(negedge clk);
    nRST = 1'b1;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    access(0, 1'b0, a, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    int d;
    n_chk = 0;
    n_err = 0;
    nRST  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; adr[i] = '0;
      dati[i] = '0; sel[i] = '0; last_rd[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_busy", 32'(busy[i]), 32'h0);
      chk("reset_err", 32'(err[i]), 32'h0);
      chk("reset_dato", dato[i], 32'h0);
    end
    nRST = 1'b1;

    for (int i = 0; i < 256; i++)
      access(0, 1'b1, 32'(4 * i), $urandom, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      access(1, 1'b1, 32'h1000 + 32'(4 * i), $urandom, 4'hF, 1'b0, 1'b0);

    access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("deadbeef", dato[0], 32'hDEAD_BEEF);

    access(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
    access(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0);
    access(0, 1'b0, 32'h22, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("lanes", dato[0], 32'h11BB_33DD);

    access(0, 1'b1, 32'h24, 32'h5555_AAAA, 4'h0, 1'b0, 1'b0);
    access(0, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0, 1'b0);

    access(0, 1'b1, 32'h10, 32'h0BAD_F00D, 4'hF, 1'b1, 1'b0);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
    chk("late_adr", dato[0], 32'h0BAD_F00D);

    access(0, 1'b0, 32'h400, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("oor_data", dato[0], 32'hBAD0_BAD0);
    access(0, 1'b1, 32'h400, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
    access(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    access(1, 1'b0, 32'h0FFC, 32'h0, 4'h0, 1'b0, 1'b0);
    access(1, 1'b1, 32'h1040, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
    access(1, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, 1'b0);

    access(0, 1'b1, 32'h30, 32'hCAFE_0001, 4'hF, 1'b0, 1'b1);
    access(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 1'b0);

    reset_mid(32'h10);
    back2back(32'h1008, 32'h1034);

    for (int i = 0; i < 250; i++) begin
      d = int'($urandom_range(0, 1));
      a = base(d) - 32'd8 +
          32'($urandom_range(0, 4 * words(d) + 15));
      access(d, 1'($urandom), a, $urandom, 4'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
